// File: rtl/register_file_bank.sv
// register_file_bank
//   Dual-write, dual-read register file sitting between decode (read
//   addresses) and writeback (ALU result on port 0, load result on port 1).
//   Reads are combinational. A sequenced bulk-clear engine rewrites every
//   entry with its reset value, one entry per clock, and reports Busy and a
//   ClearDone pulse. Writes that arrive while the engine runs are discarded
//   and flagged with a WriteDropped pulse.
//
//   Optional feature macro: WRITE_BYPASS_EN
//     defined   - a read whose address matches a write committing this cycle
//                 returns that write's data combinationally (port 1 first).
//     undefined - reads return the stored contents; a write becomes visible
//                 the cycle after it commits.
module register_file_bank #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int RESET_MODE = 1,  // 0: entries reset to 0, 1: entry i resets to i
  parameter int ZERO_REG   = 0   // 1: entry 0 reads as 0 and ignores writes
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  WriteEnable0,
  input  logic [ADDR_WIDTH-1:0] WriteAddress0,
  input  logic [DATA_WIDTH-1:0] WriteData0,
  input  logic                  WriteEnable1,
  input  logic [ADDR_WIDTH-1:0] WriteAddress1,
  input  logic [DATA_WIDTH-1:0] WriteData1,
  input  logic [ADDR_WIDTH-1:0] ReadAddress1,
  input  logic [ADDR_WIDTH-1:0] ReadAddress2,
  input  logic                  ClearStart,
  output logic [DATA_WIDTH-1:0] OutData1,
  output logic [DATA_WIDTH-1:0] OutData2,
  output logic                  Busy,
  output logic                  ClearDone,
  output logic                  WriteDropped
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] clear_ptr;
  logic                  done_q;
  logic                  dropped_q;
  logic                  idle;
  logic                  wr0_ok;
  logic                  wr1_ok;

  // Value an entry holds after reset or after the clear engine visits it.
  function automatic logic [DATA_WIDTH-1:0] reset_value(input logic [ADDR_WIDTH-1:0] idx);
    if (RESET_MODE == 1) return DATA_WIDTH'(idx);
    else                 return '0;
  endfunction

  assign idle = (state == ST_IDLE);

  // A write commits only in IDLE. Entry 0 is read-only when ZERO_REG is set,
  // and port 0 yields to port 1 when both target the same entry.
  assign wr1_ok = idle && WriteEnable1 && !(ZERO_REG != 0 && WriteAddress1 == '0);
  assign wr0_ok = idle && WriteEnable0 && !(ZERO_REG != 0 && WriteAddress0 == '0)
                  && !(WriteEnable1 && WriteAddress1 == WriteAddress0);

  // Storage array: reset contents, clear-engine rewrites, and port writes.
  // NOTE: the array is reset explicitly because software relies on known
  // contents right after nRST; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= reset_value(ADDR_WIDTH'(i));
      end
    end else if (state == ST_CLEAR) begin
      mem[clear_ptr] <= reset_value(clear_ptr);
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values;
      // blocking here would create ordering-dependent simulation races.
      if (wr0_ok) mem[WriteAddress0] <= WriteData0;
      if (wr1_ok) mem[WriteAddress1] <= WriteData1;
    end
  end

  // Clear sequencer: walks clear_ptr over every entry, then pulses ClearDone.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= ST_IDLE;
      clear_ptr <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ClearStart) begin
            state     <= ST_CLEAR;
            clear_ptr <= '0;
          end
        end
        ST_CLEAR: begin
          // ClearStart is ignored here: no restart and no queued request.
          if (clear_ptr == ADDR_WIDTH'(DEPTH - 1)) begin
            state     <= ST_IDLE;
            clear_ptr <= '0;
            done_q    <= 1'b1;
          end else begin
            clear_ptr <= clear_ptr + ADDR_WIDTH'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Flag any write attempted while the clear engine owns the array.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      dropped_q <= 1'b0;
    end else begin
      dropped_q <= (state == ST_CLEAR) && (WriteEnable0 || WriteEnable1);
    end
  end

  // One read port: stored data, optional same-cycle bypass, zero-register mask.
  function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] addr);
    logic [DATA_WIDTH-1:0] value;
    value = mem[addr];
`ifdef WRITE_BYPASS_EN
    // wr*_ok already excludes Busy and the hardwired zero entry.
    if (wr1_ok && WriteAddress1 == addr)      value = WriteData1;
    else if (wr0_ok && WriteAddress0 == addr) value = WriteData0;
`endif
    if (ZERO_REG != 0 && addr == '0) value = '0;
    return value;
  endfunction

  // Combinational read ports.
  // NOTE: each output is assigned on every path through this block, so no
  // latch can be inferred.
  always_comb begin
    OutData1 = read_port(ReadAddress1);
    OutData2 = read_port(ReadAddress2);
  end

  assign Busy         = (state == ST_CLEAR);
  assign ClearDone    = done_q;
  assign WriteDropped = dropped_q;

endmodule
